lsu_mem_port: RTL and testbench

Sequential load/store front end for the RISC-V core's data-memory port; it sits directly upstream of the load-extension stage. It accepts one memory instruction at a time from the execute stage, checks alignment, and generates the word-aligned address, byte write mask and replicated store data. It runs the valid/ready request and response handshake with data memory/MMIO, stalls the pipeline while busy, and hands the raw loaded word, byte offset and funct3 to the load extender.

---
 rtl/lsu_mem_port.sv | 171 +++++++++++++++++
 tb/tb_lsu_mem_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: one-at-a-time load/store front end for the data-memory port.
// It checks alignment and funct3, builds the aligned address, byte enables and
// lane-replicated store data, and runs the request/response handshake. The raw
// loaded word, its byte offset and funct3 go to the downstream load extender.
module lsu_mem_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_store,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        stall,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_wdata,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        ld_valid,
    output logic [31:0] ld_word,
    output logic [1:0]  ld_bits,
    output logic [2:0]  ld_funct3,
    output logic        st_done,
    output logic        err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        err_q, err_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ld_word_q, ld_word_d;
    logic [1:0]  ld_bits_q, ld_bits_d;
    logic [2:0]  ld_funct3_q, ld_funct3_d;

    // Decode of the presented instruction: legality and store byte lanes.
    logic        acc_err;
    logic [3:0]  lane_we;
    logic [31:0] lane_wdata;

    // Legality check plus store byte-enable / replicated data generation.
    always_comb begin
        acc_err    = 1'b0;
        lane_we    = 4'b0000;
        lane_wdata = 32'h0000_0000;
        case (req_funct3)
            3'b011, 3'b110, 3'b111: acc_err = 1'b1;
            default:                 ;
        endcase
        // Unsigned variants exist only for loads.
        if (req_store && req_funct3[2]) acc_err = 1'b1;
        if ((req_funct3[1:0] == 2'b01) && req_addr[0]) acc_err = 1'b1;
        if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) acc_err = 1'b1;
        if (req_store && !acc_err) begin
            case (req_funct3[1:0])
                2'b00: begin
                    lane_we    = 4'b0001 << req_addr[1:0];
                    lane_wdata = {4{req_wdata[7:0]}};
                end
                2'b01: begin
                    lane_we    = 4'b0011 << {req_addr[1], 1'b0};
                    lane_wdata = {2{req_wdata[15:0]}};
                end
                2'b10: begin
                    lane_we    = 4'b1111;
                    lane_wdata = req_wdata;
                end
                default: ;
            endcase
        end
    end

    // Next-state logic; every register holds unless its state updates it.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        store_d     = store_q;
        funct3_d    = funct3_q;
        err_d       = err_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        ld_word_d   = ld_word_q;
        ld_bits_d   = ld_bits_q;
        ld_funct3_d = ld_funct3_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    err_d    = acc_err;
                    we_d     = lane_we;
                    wdata_d  = lane_wdata;
                    state_d  = acc_err ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // A response in the handshake cycle is deliberately not taken.
                if (mem_req_ready) state_d = store_q ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                if (mem_rsp_valid) begin
                    ld_word_d   = mem_rsp_data;
                    ld_bits_d   = addr_q[1:0];
                    ld_funct3_d = funct3_q;
                    state_d     = S_DONE;
                end
            end
            S_DONE: begin
                // req_valid still shows the finished instruction here; ignore it.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= 32'h0000_0000;
            store_q     <= 1'b0;
            funct3_q    <= 3'b000;
            err_q       <= 1'b0;
            we_q        <= 4'b0000;
            wdata_q     <= 32'h0000_0000;
            ld_word_q   <= 32'h0000_0000;
            ld_bits_q   <= 2'b00;
            ld_funct3_q <= 3'b000;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            store_q     <= store_d;
            funct3_q    <= funct3_d;
            err_q       <= err_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            ld_word_q   <= ld_word_d;
            ld_bits_q   <= ld_bits_d;
            ld_funct3_q <= ld_funct3_d;
        end
    end

    // Output decode: completion pulses come straight from DONE.
    always_comb begin
        stall         = ((state_q == S_IDLE) && req_valid) ||
                        (state_q == S_REQ) || (state_q == S_WAIT);
        mem_req_valid = (state_q == S_REQ);
        mem_addr      = {addr_q[31:2], 2'b00};
        mem_we        = we_q;
        mem_wdata     = wdata_q;
        ld_valid      = (state_q == S_DONE) && !store_q && !err_q;
        st_done       = (state_q == S_DONE) &&  store_q && !err_q;
        err           = (state_q == S_DONE) &&  err_q;
        ld_word       = ld_word_q;
        ld_bits       = ld_bits_q;
        ld_funct3     = ld_funct3_q;
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: scoreboard of expected completions, cycle-accurate
// handshake driving, back-pressure, back-to-back and mid-transaction reset.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_store;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        stall, mem_req_valid, mem_req_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rsp_data, ld_word;
    logic [3:0]  mem_we;
    logic        mem_rsp_valid, ld_valid, st_done, err;
    logic [1:0]  ld_bits;
    logic [2:0]  ld_funct3;

    always #5 clk = ~clk;

    lsu_mem_port dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_store     (req_store),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_funct3    (req_funct3),
        .stall         (stall),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_addr      (mem_addr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .ld_valid      (ld_valid),
        .ld_word       (ld_word),
        .ld_bits       (ld_bits),
        .ld_funct3     (ld_funct3),
        .st_done       (st_done),
        .err           (err)
    );

    typedef struct {
        int          kind;   // 0 load, 1 store, 2 error
        logic [31:0] word;
        logic [1:0]  bits;
        logic [2:0]  f3;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic model_err(input logic st, input logic [31:0] a, input logic [2:0] f3);
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
        if (st && f3[2]) return 1'b1;
        if (f3[1:0] == 2'b01 && a[0]) return 1'b1;
        if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Per-lane reference: which lanes a store touches and what byte lands there.
    function automatic logic [3:0] model_we(input logic [31:0] a, input logic [2:0] f3);
        logic [3:0] w;
        w = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            logic [1:0] li;
            li = 2'(i);
            if (f3[1:0] == 2'b00) w[i] = (li == a[1:0]);
            else if (f3[1:0] == 2'b01) w[i] = (li[1] == a[1]);
            else w[i] = 1'b1;
        end
        return w;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [2:0] f3);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (f3[1:0] == 2'b00) r[8*i +: 8] = wd[7:0];
            else if (f3[1:0] == 2'b01) r[8*i +: 8] = (i % 2 == 1) ? wd[15:8] : wd[7:0];
            else r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    // Pop and compare whenever a completion pulse is visible.
    task automatic sample(input string name, input int c);
        exp_t e;
        int   k;
        if (ld_valid || st_done || err) begin
            k = ld_valid ? 0 : (st_done ? 1 : 2);
            if (sb_q.size() == 0) begin
                check({name, ".spurious_pulse"}, {29'd0, ld_valid, st_done, err}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check({name, ".kind"}, k, e.kind);
                check({name, ".cycle"}, c, e.cyc);
                check({name, ".onehot"}, 32'(ld_valid) + 32'(st_done) + 32'(err), 32'd1);
                if (e.kind == 0) begin
                    check({name, ".ld_word"}, ld_word, e.word);
                    check({name, ".ld_bits"}, {30'd0, ld_bits}, {30'd0, e.bits});
                    check({name, ".ld_funct3"}, {29'd0, ld_funct3}, {29'd0, e.f3});
                end
            end
        end
    endtask

    // One instruction from acceptance (current negedge = cycle 0) through the IDLE after DONE.
    task automatic run_op(input string name, input logic st, input logic [31:0] a,
                          input logic [31:0] wd, input logic [2:0] f3, input int rdy_lat,
                          input int gap, input logic stray, input logic [31:0] rsp);
        logic        e;
        logic [3:0]  we;
        logic [31:0] wdat;
        int          hs, done;
        exp_t        x;
        e    = model_err(st, a, f3);
        we   = (st && !e) ? model_we(a, f3) : 4'b0000;
        wdat = model_wdata(wd, f3);
        hs   = 1 + rdy_lat;
        done = e ? 1 : (st ? hs + 1 : hs + gap + 1);
        x.kind = e ? 2 : (st ? 1 : 0);
        x.word = rsp;
        x.bits = a[1:0];
        x.f3   = f3;
        x.cyc  = done;
        sb_q.push_back(x);

        req_valid = 1'b1; req_store = st; req_addr = a; req_wdata = wd; req_funct3 = f3;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = $urandom;
        #1;
        check({name, ".stall_c0"}, {31'd0, stall}, 32'd1);
        check({name, ".reqv_c0"}, {31'd0, mem_req_valid}, 32'd0);

        for (int c = 1; c <= done; c++) begin
            @(negedge clk);
            sample(name, c);
            check({name, ".stall"}, {31'd0, stall}, (c < done) ? 32'd1 : 32'd0);
            check({name, ".mem_req_valid"}, {31'd0, mem_req_valid},
                  (!e && c <= hs) ? 32'd1 : 32'd0);
            if (!e && c <= hs) begin
                check({name, ".mem_addr"}, mem_addr, {a[31:2], 2'b00});
                check({name, ".mem_we"}, {28'd0, mem_we}, {28'd0, we});
                if (st) check({name, ".mem_wdata"}, mem_wdata, wdat);
            end
            mem_req_ready = (!e && c == hs);
            mem_rsp_valid = 1'b0;
            mem_rsp_data  = $urandom;
            if (!e && !st && c == hs + gap) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp;
            end else if (stray && !e && (c == 1 || c == hs)) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 32'hBAD0_0000 | c;
            end
        end
        check({name, ".pending"}, sb_q.size(), 32'd0);
        sb_q.delete();

        // IDLE after DONE, req_valid still held with the finished instruction.
        @(negedge clk);
        sample(name, done + 1);
        check({name, ".no_dup_req"}, {31'd0, mem_req_valid}, 32'd0);
        if (!st && !e) check({name, ".ld_word_hold"}, ld_word, rsp);
        req_valid = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = 32'h0;
        req_wdata = 32'h0; req_funct3 = 3'b000; mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        repeat (2) @(negedge clk);
        check("rst.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("rst.mem_we", {28'd0, mem_we}, 32'd0);
        check("rst.mem_addr", mem_addr, 32'd0);
        check("rst.ld_word", ld_word, 32'd0);
        check("rst.pulses", {29'd0, ld_valid, st_done, err}, 32'd0);
        check("rst.stall_lo", {31'd0, stall}, 32'd0);
        req_valid = 1'b1;
        #1 check("rst.stall_follows", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);

        run_op("lw",     1'b0, 32'h1000_0008, 32'h0, 3'b010, 0, 1, 1'b0, 32'hDEAD_BEEF);
        run_op("sb",     1'b1, 32'h0000_2003, 32'h1234_56A5, 3'b000, 0, 1, 1'b0, 32'h0);
        run_op("sh",     1'b1, 32'h0000_2002, 32'h1234_56A5, 3'b001, 0, 1, 1'b0, 32'h0);
        run_op("lw_mis", 1'b0, 32'h0000_3002, 32'h0, 3'b010, 0, 1, 1'b0, 32'h0);
        run_op("lh_mis", 1'b0, 32'h0000_3001, 32'h0, 3'b001, 0, 1, 1'b0, 32'h0);
        run_op("f3_110", 1'b0, 32'h0000_3000, 32'h0, 3'b110, 0, 1, 1'b0, 32'h0);
        run_op("st_uns", 1'b1, 32'h0000_3000, 32'h0, 3'b101, 0, 1, 1'b0, 32'h0);
        run_op("sb_odd", 1'b1, 32'h0000_3003, 32'hCAFE_F00D, 3'b000, 0, 1, 1'b0, 32'h0);
        run_op("bp_lh",  1'b0, 32'h0000_4002, 32'h0, 3'b001, 5, 4, 1'b1, 32'h8765_4321);
        run_op("b2b_lbu", 1'b0, 32'h0000_5001, 32'h0, 3'b100, 0, 1, 1'b0, 32'h1122_3344);
        run_op("b2b_sw", 1'b1, 32'h0000_5004, 32'hA1B2_C3D4, 3'b010, 0, 1, 1'b0, 32'h0);

        // Reset while waiting for a load response.
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h6000_0004; req_funct3 = 3'b010;
        @(negedge clk) mem_req_ready = 1'b1;
        @(negedge clk) mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
        check("mid_rst.mem_addr", mem_addr, 32'd0);
        check("mid_rst.mem_we", {28'd0, mem_we}, 32'd0);
        check("mid_rst.mem_wdata", mem_wdata, 32'd0);
        check("mid_rst.ld_word", ld_word, 32'd0);
        check("mid_rst.ld_meta", {27'd0, ld_bits, ld_funct3}, 32'd0);
        check("mid_rst.pulses", {29'd0, ld_valid, st_done, err}, 32'd0);
        check("mid_rst.stall", {31'd0, stall}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBADC_0FFE;
            @(negedge clk);
            check("post_rst.ld_valid", {31'd0, ld_valid}, 32'd0);
            check("post_rst.mem_req_valid", {31'd0, mem_req_valid}, 32'd0);
            check("post_rst.ld_word", ld_word, 32'd0);
        end
        mem_rsp_valid = 1'b0;
        run_op("lw_after_rst", 1'b0, 32'h7000_0010, 32'h0, 3'b010, 1, 2, 1'b0, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
